// File: rtl/shift_rotate_ctrl_pkg.sv
// Shared types and constants for the shift/rotate issue controller.
package shift_rotate_ctrl_pkg;

  localparam int unsigned SR_LATENCY_DEFAULT = 4;
  localparam int unsigned SR_ADDR_WD         = 7;
  localparam int unsigned SR_DATA_WD         = 128;
  localparam int unsigned SR_I7_WD           = 7;

  typedef enum logic [2:0] {
    SHIFT_LEFT_HALFWORD           = 3'd0,
    SHIFT_LEFT_HALFWORD_IMMEDIATE = 3'd1,
    SHIFT_LEFT_WORD               = 3'd2,
    SHIFT_LEFT_WORD_IMMEDIATE     = 3'd3,
    ROTATE_HALFWORD               = 3'd4,
    ROTATE_HALFWORD_IMMEDIATE     = 3'd5,
    ROTATE_WORD                   = 3'd6,
    ROTATE_WORD_IMMEDIATE         = 3'd7
  } opcodes_t;

  // One issue-slot request as seen by the controller.
  typedef struct packed {
    opcodes_t                opcode;
    logic [SR_DATA_WD-1:0]   ra;
    logic [SR_DATA_WD-1:0]   rb;
    logic [SR_I7_WD-1:0]     i7;
    logic [SR_ADDR_WD-1:0]   ra_addr;
    logic [SR_ADDR_WD-1:0]   rb_addr;
    logic [SR_ADDR_WD-1:0]   rt_addr;
  } sr_req_t;

  // One result-pipeline stage.
  typedef struct packed {
    logic                    valid;
    logic [SR_ADDR_WD-1:0]   rt_addr;
    logic [SR_DATA_WD-1:0]   data;
  } sr_stage_t;

endpackage

// File: rtl/shift_rotate_ctrl_rr_arb2.sv
// Two-request round-robin arbiter with a one-bit priority pointer.
module shift_rotate_ctrl_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant the pointed-to slot on contention, otherwise whichever requests.
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
  end

  // After a grant, priority passes to the other slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (gnt[0]) begin
      ptr <= 1'b1;
    end else if (gnt[1]) begin
      ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/shift_rotate_ctrl.sv
// Issue controller: arbitrates two slots onto the shift/rotate unit and
// carries results through a fixed-latency pipeline to writeback.
module shift_rotate_ctrl
  import shift_rotate_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WD = SR_ADDR_WD,
  parameter int unsigned REG_DATA_WD = SR_DATA_WD,
  parameter int unsigned SR_LATENCY  = SR_LATENCY_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  output logic                   req0_ready,
  input  opcodes_t               req0_opcode,
  input  logic [REG_DATA_WD-1:0] req0_ra,
  input  logic [REG_DATA_WD-1:0] req0_rb,
  input  logic [6:0]             req0_i7,
  input  logic [REG_ADDR_WD-1:0] req0_ra_addr,
  input  logic [REG_ADDR_WD-1:0] req0_rb_addr,
  input  logic [REG_ADDR_WD-1:0] req0_rt_addr,
  input  logic                   req1_valid,
  output logic                   req1_ready,
  input  opcodes_t               req1_opcode,
  input  logic [REG_DATA_WD-1:0] req1_ra,
  input  logic [REG_DATA_WD-1:0] req1_rb,
  input  logic [6:0]             req1_i7,
  input  logic [REG_ADDR_WD-1:0] req1_ra_addr,
  input  logic [REG_ADDR_WD-1:0] req1_rb_addr,
  input  logic [REG_ADDR_WD-1:0] req1_rt_addr,
  input  logic                   flush,
  output opcodes_t               sr_opcode,
  output logic [REG_DATA_WD-1:0] sr_ra,
  output logic [REG_DATA_WD-1:0] sr_rb,
  output logic [6:0]             sr_i7,
  input  logic [REG_DATA_WD-1:0] sr_result,
  output logic                   wb_valid,
  output logic [REG_ADDR_WD-1:0] wb_rt_addr,
  output logic [REG_DATA_WD-1:0] wb_data
);

  if (SR_LATENCY < 2 || SR_LATENCY > 8) begin : g_bad_latency
    $error("shift_rotate_ctrl: SR_LATENCY must be within 2..8");
  end

  sr_req_t                req_s [2];
  logic [1:0]             elig;
  logic [1:0]             gnt;
  logic                   s1_valid;
  logic [SR_ADDR_WD-1:0]  s1_rt;
  sr_stage_t              pipe [2:SR_LATENCY];
  logic [SR_LATENCY-1:0]  stg_valid;
  logic [SR_ADDR_WD-1:0]  stg_rt [SR_LATENCY];
  logic [SR_LATENCY-1:0]  hit0;
  logic [SR_LATENCY-1:0]  hit1;

  // Gather each slot's fields into a request record.
  always_comb begin
    req_s[0] = '{opcode:  req0_opcode,
                 ra:      SR_DATA_WD'(req0_ra),
                 rb:      SR_DATA_WD'(req0_rb),
                 i7:      SR_I7_WD'(req0_i7),
                 ra_addr: SR_ADDR_WD'(req0_ra_addr),
                 rb_addr: SR_ADDR_WD'(req0_rb_addr),
                 rt_addr: SR_ADDR_WD'(req0_rt_addr)};
    req_s[1] = '{opcode:  req1_opcode,
                 ra:      SR_DATA_WD'(req1_ra),
                 rb:      SR_DATA_WD'(req1_rb),
                 i7:      SR_I7_WD'(req1_i7),
                 ra_addr: SR_ADDR_WD'(req1_ra_addr),
                 rb_addr: SR_ADDR_WD'(req1_rb_addr),
                 rt_addr: SR_ADDR_WD'(req1_rt_addr)};
  end

  // Scoreboard: every stage up to and including writeback blocks its rt.
  assign stg_valid[0] = s1_valid;
  assign stg_rt[0]    = s1_rt;
  for (genvar k = 1; k < SR_LATENCY; k++) begin : g_stg_view
    assign stg_valid[k] = pipe[k+1].valid;
    assign stg_rt[k]    = pipe[k+1].rt_addr;
  end

  for (genvar k = 0; k < SR_LATENCY; k++) begin : g_scoreboard
    assign hit0[k] = stg_valid[k] &&
                     (stg_rt[k] == req_s[0].ra_addr || stg_rt[k] == req_s[0].rb_addr);
    assign hit1[k] = stg_valid[k] &&
                     (stg_rt[k] == req_s[1].ra_addr || stg_rt[k] == req_s[1].rb_addr);
  end

  assign elig[0] = req0_valid && !flush && !rst && !(|hit0);
  assign elig[1] = req1_valid && !flush && !rst && !(|hit1);

  shift_rotate_ctrl_rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (elig),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  // Stage 1: issue register driving the shift/rotate unit; holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_rt     <= '0;
      sr_opcode <= SHIFT_LEFT_HALFWORD;
      sr_ra     <= '0;
      sr_rb     <= '0;
      sr_i7     <= '0;
    end else begin
      s1_valid <= |gnt;
      if (|gnt) begin
        s1_rt     <= gnt[1] ? req_s[1].rt_addr : req_s[0].rt_addr;
        sr_opcode <= gnt[1] ? req_s[1].opcode : req_s[0].opcode;
        sr_ra     <= REG_DATA_WD'(gnt[1] ? req_s[1].ra : req_s[0].ra);
        sr_rb     <= REG_DATA_WD'(gnt[1] ? req_s[1].rb : req_s[0].rb);
        sr_i7     <= 7'(gnt[1] ? req_s[1].i7 : req_s[0].i7);
      end
    end
  end

  // Stage 2: capture the unit's combinational result.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe[2] <= '0;
    end else begin
      pipe[2] <= '{valid:   s1_valid && !flush,
                   rt_addr: s1_rt,
                   data:    SR_DATA_WD'(sr_result)};
    end
  end

  // Stages 3..SR_LATENCY: plain delay line; flush clears the valids.
  for (genvar k = 3; k <= SR_LATENCY; k++) begin : g_pipe
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe[k] <= '0;
      end else begin
        pipe[k] <= '{valid:   pipe[k-1].valid && !flush,
                     rt_addr: pipe[k-1].rt_addr,
                     data:    pipe[k-1].data};
      end
    end
  end

  // A flush or reset in the writeback cycle suppresses the strobe.
  assign wb_valid   = pipe[SR_LATENCY].valid && !flush && !rst;
  assign wb_rt_addr = REG_ADDR_WD'(pipe[SR_LATENCY].rt_addr);
  assign wb_data    = REG_DATA_WD'(pipe[SR_LATENCY].data);

endmodule

// File: tb/tb_shift_rotate_ctrl.sv
// Bench for shift_rotate_ctrl: directed vector table, hand-written
// single-issue sequence, then random traffic against a queue-based model.
module tb_shift_rotate_ctrl;
  import shift_rotate_ctrl_pkg::*;

  localparam int L = 4;

  logic         clk, rst, flush;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  opcodes_t     req0_opcode, req1_opcode, sr_opcode;
  logic [127:0] req0_ra, req0_rb, req1_ra, req1_rb;
  logic [127:0] sr_ra, sr_rb, sr_result, wb_data;
  logic [6:0]   req0_i7, req1_i7, sr_i7;
  logic [6:0]   req0_ra_addr, req0_rb_addr, req0_rt_addr;
  logic [6:0]   req1_ra_addr, req1_rb_addr, req1_rt_addr;
  logic         wb_valid;
  logic [6:0]   wb_rt_addr;

  shift_rotate_ctrl #(.SR_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_opcode(req0_opcode),
    .req0_ra(req0_ra), .req0_rb(req0_rb), .req0_i7(req0_i7),
    .req0_ra_addr(req0_ra_addr), .req0_rb_addr(req0_rb_addr), .req0_rt_addr(req0_rt_addr),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_opcode(req1_opcode),
    .req1_ra(req1_ra), .req1_rb(req1_rb), .req1_i7(req1_i7),
    .req1_ra_addr(req1_ra_addr), .req1_rb_addr(req1_rb_addr), .req1_rt_addr(req1_rt_addr),
    .flush(flush),
    .sr_opcode(sr_opcode), .sr_ra(sr_ra), .sr_rb(sr_rb), .sr_i7(sr_i7),
    .sr_result(sr_result),
    .wb_valid(wb_valid), .wb_rt_addr(wb_rt_addr), .wb_data(wb_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Behavioural shift/rotate unit: halfword lanes use 5-bit counts, word lanes 6-bit.
  function automatic logic [127:0] sru(input opcodes_t op, input logic [127:0] a,
                                       input logic [127:0] b, input logic [6:0] i7);
    logic [127:0] r;
    logic [31:0]  t;
    logic [63:0]  u;
    int           c;
    bit           imm, rot;
    r   = '0;
    imm = (op == SHIFT_LEFT_HALFWORD_IMMEDIATE) || (op == SHIFT_LEFT_WORD_IMMEDIATE) ||
          (op == ROTATE_HALFWORD_IMMEDIATE) || (op == ROTATE_WORD_IMMEDIATE);
    rot = (op == ROTATE_HALFWORD) || (op == ROTATE_HALFWORD_IMMEDIATE) ||
          (op == ROTATE_WORD) || (op == ROTATE_WORD_IMMEDIATE);
    if (op == SHIFT_LEFT_HALFWORD || op == SHIFT_LEFT_HALFWORD_IMMEDIATE ||
        op == ROTATE_HALFWORD || op == ROTATE_HALFWORD_IMMEDIATE) begin
      for (int l = 0; l < 8; l++) begin
        c = imm ? int'(i7[4:0]) : int'(b[16*l +: 5]);
        if (rot) begin
          t = {a[16*l +: 16], a[16*l +: 16]} << (c % 16);
          r[16*l +: 16] = t[31:16];
        end else begin
          t = {16'h0, a[16*l +: 16]} << c;
          r[16*l +: 16] = (c > 15) ? 16'h0 : t[15:0];
        end
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        c = imm ? int'(i7[5:0]) : int'(b[32*l +: 6]);
        if (rot) begin
          u = {a[32*l +: 32], a[32*l +: 32]} << (c % 32);
          r[32*l +: 32] = u[63:32];
        end else begin
          u = {32'h0, a[32*l +: 32]} << c;
          r[32*l +: 32] = (c > 31) ? 32'h0 : u[31:0];
        end
      end
    end
    return r;
  endfunction

  always_comb sr_result = sru(sr_opcode, sr_ra, sr_rb, sr_i7);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: list of accepted instructions with their writeback cycle.
  typedef struct {
    int           due;
    logic [6:0]   rt;
    logic [127:0] data;
  } wb_t;

  wb_t          q[$];
  int           cyc = 0;
  bit           ptr = 1'b0;
  bit           m_r0, m_r1, m_wb;
  logic [6:0]   m_rt;
  logic [127:0] m_data;
  logic         s_r0, s_r1, s_wb;
  logic [6:0]   s_rt;
  logic [127:0] s_data;

  task automatic model_eval();
    bit h0, h1, e0, e1;
    h0 = 1'b0;
    h1 = 1'b0;
    foreach (q[i]) begin
      if (q[i].rt == req0_ra_addr || q[i].rt == req0_rb_addr) h0 = 1'b1;
      if (q[i].rt == req1_ra_addr || q[i].rt == req1_rb_addr) h1 = 1'b1;
    end
    e0 = req0_valid && !flush && !rst && !h0;
    e1 = req1_valid && !flush && !rst && !h1;
    m_r0 = e0 && (!e1 || !ptr);
    m_r1 = e1 && (!e0 || ptr);
    m_wb = 1'b0;
    m_rt = '0;
    m_data = '0;
    foreach (q[i]) begin
      if (q[i].due == cyc && !flush && !rst) begin
        m_wb = 1'b1;
        m_rt = q[i].rt;
        m_data = q[i].data;
      end
    end
  endtask

  task automatic model_update();
    wb_t e;
    if (rst) begin
      q.delete();
      ptr = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
      if (m_r0) begin
        e.due = cyc + L; e.rt = req0_rt_addr;
        e.data = sru(req0_opcode, req0_ra, req0_rb, req0_i7);
        q.push_back(e);
        ptr = 1'b1;
      end else if (m_r1) begin
        e.due = cyc + L; e.rt = req1_rt_addr;
        e.data = sru(req1_opcode, req1_ra, req1_rb, req1_i7);
        q.push_back(e);
        ptr = 1'b0;
      end
    end
    cyc++;
  endtask

  // One clock: sample outputs at the falling edge, advance the model at the rising edge.
  task automatic run_cycle(input bit use_model);
    model_eval();
    @(negedge clk);
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    s_wb = wb_valid;
    s_rt = wb_rt_addr;
    s_data = wb_data;
    if (use_model) begin
      chk("rnd_ready0", 128'(s_r0), 128'(m_r0));
      chk("rnd_ready1", 128'(s_r1), 128'(m_r1));
      chk("rnd_wb_valid", 128'(s_wb), 128'(m_wb));
      if (m_wb) begin
        chk("rnd_wb_rt", 128'(s_rt), 128'(m_rt));
        chk("rnd_wb_data", s_data, m_data);
      end
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct packed {
    bit rst, flush, v0;
    logic [6:0] a0, t0;
    bit v1;
    logic [6:0] a1, t1;
    bit r0, r1, wb;
    logic [6:0] wrt;
  } vec_t;

  function automatic vec_t mk(bit r, bit f, bit v0, int a0, int t0, bit v1, int a1, int t1,
                              bit r0, bit r1, bit wb, int wrt);
    vec_t v;
    v = '{r, f, v0, 7'(a0), 7'(t0), v1, 7'(a1), 7'(t1), r0, r1, wb, 7'(wrt)};
    return v;
  endfunction

  vec_t tbl [30];

  task automatic idle_inputs();
    rst = 1'b0;
    flush = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    logic [127:0] pat_a, pat_r;

    // contention, RAW, flush and reset-mid-flight cycles (slot rb_addr fixed at 100)
    tbl[0]  = mk(1,0, 1,10,20, 1,11,21, 0,0, 0,0);
    tbl[1]  = mk(1,0, 1,10,20, 1,11,21, 0,0, 0,0);
    tbl[2]  = mk(0,0, 1,10,20, 1,11,21, 1,0, 0,0);
    tbl[3]  = mk(0,0, 1,12,22, 1,11,21, 0,1, 0,0);
    tbl[4]  = mk(0,0, 1,12,22, 1,13,23, 1,0, 0,0);
    tbl[5]  = mk(0,0, 0, 0, 0, 1,13,23, 0,1, 0,0);
    tbl[6]  = mk(0,0, 1,20,30, 0, 0, 0, 0,0, 1,20);
    tbl[7]  = mk(0,0, 1,20,30, 0, 0, 0, 1,0, 1,21);
    tbl[8]  = mk(0,0, 0, 0, 0, 1,30,31, 0,0, 1,22);
    tbl[9]  = mk(0,0, 0, 0, 0, 1,30,31, 0,0, 1,23);
    tbl[10] = mk(0,0, 0, 0, 0, 1,30,31, 0,0, 0,0);
    tbl[11] = mk(0,0, 0, 0, 0, 1,30,31, 0,0, 1,30);
    tbl[12] = mk(0,0, 0, 0, 0, 1,30,31, 0,1, 0,0);
    tbl[13] = mk(0,0, 1,44,45, 0, 0, 0, 1,0, 0,0);
    tbl[14] = mk(0,1, 1,40,41, 1,42,43, 0,0, 0,0);
    tbl[15] = mk(0,0, 1,40,41, 1,42,43, 0,1, 0,0);
    tbl[16] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[17] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[18] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[19] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 1,43);
    tbl[20] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[21] = mk(0,0, 1,50,51, 1,52,53, 1,0, 0,0);
    tbl[22] = mk(0,0, 1,54,55, 0, 0, 0, 1,0, 0,0);
    tbl[23] = mk(1,0, 1,50,51, 1,52,53, 0,0, 0,0);
    tbl[24] = mk(0,0, 1,50,51, 1,52,53, 1,0, 0,0);
    tbl[25] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[26] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[27] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);
    tbl[28] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 1,51);
    tbl[29] = mk(0,0, 0, 0, 0, 0, 0, 0, 0,0, 0,0);

    rst = 1'b1;
    flush = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = ROTATE_WORD_IMMEDIATE; req1_opcode = SHIFT_LEFT_WORD;
    req0_ra = {4{32'h89ab_cdef}}; req0_rb = {4{32'h0000_0003}};
    req1_ra = {4{32'h1234_5678}}; req1_rb = {4{32'h0000_0005}};
    req0_i7 = 7'd9; req1_i7 = 7'd2;
    req0_ra_addr = '0; req0_rb_addr = 7'd100; req0_rt_addr = '0;
    req1_ra_addr = '0; req1_rb_addr = 7'd100; req1_rt_addr = '0;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      flush = tbl[i].flush;
      req0_valid = tbl[i].v0; req0_ra_addr = tbl[i].a0; req0_rt_addr = tbl[i].t0;
      req1_valid = tbl[i].v1; req1_ra_addr = tbl[i].a1; req1_rt_addr = tbl[i].t1;
      run_cycle(1'b0);
      chk($sformatf("vec%0d_ready0", i), 128'(s_r0), 128'(tbl[i].r0));
      chk($sformatf("vec%0d_ready1", i), 128'(s_r1), 128'(tbl[i].r1));
      chk($sformatf("vec%0d_wb_valid", i), 128'(s_wb), 128'(tbl[i].wb));
      if (tbl[i].wb) chk($sformatf("vec%0d_wb_rt", i), 128'(s_rt), 128'(tbl[i].wrt));
      if (i == 1) begin
        chk("reset_sr_opcode", 128'(sr_opcode), 128'(0));
        chk("reset_sr_ra", sr_ra, 128'(0));
        chk("reset_sr_rb", sr_rb, 128'(0));
        chk("reset_sr_i7", 128'(sr_i7), 128'(0));
        chk("reset_wb_rt", 128'(wb_rt_addr), 128'(0));
        chk("reset_wb_data", wb_data, 128'(0));
      end
    end

    // Single issue: halfword shift-left by immediate 4, writeback exactly L cycles later.
    pat_a = {8{16'h2132}};
    pat_r = {8{16'h1320}};
    idle_inputs();
    req0_valid = 1'b1;
    req0_opcode = SHIFT_LEFT_HALFWORD_IMMEDIATE;
    req0_ra = pat_a; req0_rb = '0; req0_i7 = 7'd4;
    req0_ra_addr = 7'd1; req0_rb_addr = 7'd2; req0_rt_addr = 7'd5;
    run_cycle(1'b0);
    chk("single_ready0", 128'(s_r0), 128'(1));
    req0_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      run_cycle(1'b0);
      if (k == 1) chk("single_sr_ra", sr_ra, pat_a);
      chk($sformatf("single_wb_valid_c%0d", k), 128'(s_wb), 128'(k == L));
      if (k == L) begin
        chk("single_wb_rt", 128'(s_rt), 128'(5));
        chk("single_wb_data", s_data, pat_r);
      end
    end
    chk("hold_sr_i7", 128'(sr_i7), 128'(4));
    chk("hold_sr_opcode", 128'(sr_opcode), 128'(SHIFT_LEFT_HALFWORD_IMMEDIATE));

    // Random traffic against the model, starting from a clean reset.
    idle_inputs();
    rst = 1'b1;
    run_cycle(1'b1);
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 24) == 0);
      req0_valid = ($urandom_range(0, 9) < 7);
      req1_valid = ($urandom_range(0, 9) < 7);
      req0_opcode = opcodes_t'($urandom_range(0, 7));
      req1_opcode = opcodes_t'($urandom_range(0, 7));
      req0_ra = {$urandom, $urandom, $urandom, $urandom};
      req0_rb = {$urandom, $urandom, $urandom, $urandom};
      req1_ra = {$urandom, $urandom, $urandom, $urandom};
      req1_rb = {$urandom, $urandom, $urandom, $urandom};
      req0_i7 = 7'($urandom);
      req1_i7 = 7'($urandom);
      req0_ra_addr = 7'($urandom_range(0, 11));
      req0_rb_addr = 7'($urandom_range(0, 11));
      req0_rt_addr = 7'($urandom_range(0, 11));
      req1_ra_addr = 7'($urandom_range(0, 11));
      req1_rb_addr = 7'($urandom_range(0, 11));
      req1_rt_addr = 7'($urandom_range(0, 11));
      run_cycle(1'b1);
    end
    idle_inputs();
    for (int n = 0; n < L + 2; n++) run_cycle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_rotate_ctrl.md
# shift_rotate_ctrl

Issue controller for the SPU-Lite shift/rotate execution unit. It arbitrates two issue slots (req0, req1) onto the single combinational `shift_rotate` unit using round-robin, registers the operands that drive the unit, and carries the result through a fixed-latency pipeline to register-file writeback. A small scoreboard stalls any request whose source registers are still in flight, and a flush input squashes all in-flight work.

## Interface
Parameters:
- REG_ADDR_WD, 7, register address width
- REG_DATA_WD, 128, register data width
- SR_LATENCY, 4, accept-to-writeback latency in cycles; legal range 2..8

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- reqN_valid  in  1  slot N request valid (N = 0, 1)
- reqN_ready  out  1  slot N accepted this cycle when valid && ready
- reqN_opcode  in  Opcodes  slot N opcode
- reqN_ra, reqN_rb  in  REG_DATA_WD  slot N operand data
- reqN_i7  in  7  slot N immediate
- reqN_ra_addr, reqN_rb_addr, reqN_rt_addr  in  REG_ADDR_WD  slot N source and destination addresses
- flush  in  1  squash all in-flight and same-cycle requests
- sr_opcode, sr_ra, sr_rb, sr_i7  out  —  registered drive to the shift_rotate unit
- sr_result  in  REG_DATA_WD  combinational result from the unit
- wb_valid  out  1  writeback strobe, one cycle per instruction
- wb_rt_addr  out  REG_ADDR_WD  writeback address
- wb_data  out  REG_DATA_WD  writeback data

## Operation
- **Eligibility.** Slot N is eligible when reqN_valid is high, flush is low, and neither reqN_ra_addr nor reqN_rb_addr matches the rt_addr of any valid pipeline stage (stages 1..SR_LATENCY, including the writeback stage).
- **Arbitration.** Round-robin with a 1-bit pointer; reset value is 0.
  - Both slots eligible: grant the slot named by the pointer.
  - One slot eligible: grant that slot.
  - After any grant, the pointer moves to the other slot.
  - With no grant, the pointer is unchanged.
- **Ready.** reqN_ready = (slot N granted). At most one grant per cycle.
- **Destination conflicts.** There is no rt-vs-rt check. In-order writeback makes WAW hazards harmless.
- **Stage 1 (issue register).** Captures the granted opcode, ra, rb, i7, rt_addr and valid. It drives sr_*; when stage 1 is invalid, sr_* hold their last values.
- **Stage 2.** Captures sr_result together with the stage-1 rt_addr and valid.
- **Stages 3..SR_LATENCY.** Plain shift of {valid, rt_addr, data}.
- **Writeback.** wb_* is driven by the last stage.
- **No backpressure.** The pipeline advances every cycle.
- **Flush.**
  - All stage valids clear at the next edge.
  - In the flush cycle, reqN_ready = 0 and wb_valid is forced to 0.
  - The pointer is unchanged.
- **Reset.**
  - All stage valids = 0 and the pointer = 0.
  - wb_valid = 0, reqN_ready = 0 during reset.
  - wb_rt_addr, wb_data and sr_* reset to 0.
  - Reset mid-operation drops all in-flight work without any writeback.

## Timing
- **Latency.** A handshake at edge T gives wb_valid high in cycle T+SR_LATENCY, for exactly one cycle.
- **Throughput.** One instruction per cycle when no hazards are present.
- **Dependent issue.** A dependent instruction whose source equals an in-flight rt becomes eligible only in the cycle after that rt's wb_valid cycle, because the register file is written at the end of the wb cycle.
- **Back-to-back dependents.** The issue gap is SR_LATENCY cycles.
- **Combinational ready.** reqN_ready depends combinationally on reqN_valid, the addresses, flush and the stage state. reqN_valid must not depend on reqN_ready.
- **Simultaneous flush and writeback.** wb_valid = 0 in that cycle; the instruction is lost.

## Structure
- **defines_pkg additions:**
  - `SR_LATENCY_DEFAULT` constant.
  - `sr_req_t` struct {opcode, ra, rb, i7, ra_addr, rb_addr, rt_addr}.
  - `sr_stage_t` struct {valid, rt_addr, data}.
- **Sub-module `rr_arb2`.**
  - Two-request round-robin arbiter with pointer state.
  - Inputs: clk, rst, req[1:0].
  - Output: one-hot gnt[1:0].
- **Scoreboard.** Built as a generate loop comparing source addresses against each stage.

## Test plan
- **Single issue:** SR_LATENCY=4; req0 SHIFT_LEFT_HALFWORD_IMMEDIATE, ra = 16'h2132 replicated to every halfword, i7 = 4, rt = 5, handshake at T → wb_valid at T+4, wb_rt_addr = 5, wb_data = 16'h1320 replicated to every halfword.
- **Contention:** both slots valid every cycle, independent registers → grants alternate 0,1,0,1 starting with slot 0 after reset; one wb per cycle, in grant order.
- **RAW hazard:** req0 rt = 9 accepted at T; req1 with ra_addr = 9 → req1_ready low through T+4, high at T+5.
- **Flush:** three instructions in flight, flush for one cycle → no wb_valid from the flush cycle onward; a new request after flush writes back at its normal latency.
- **Reset mid-flight:** rst asserted with two instructions in flight → wb_valid stays 0; pointer = 0 afterward, so slot 0 wins the first contended grant.
- **Same-cycle flush and request:** req0_valid with flush high → req0_ready = 0 and the pointer is unchanged.
